// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and sizing helpers for the digit-serial
// adder/subtractor.
package serial_addsub_pkg;

  // Control states of the serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the digit counter for a given digit count. A single-digit
  // instance still needs a 1-bit counter so the register is never zero-width.
  function automatic int cnt_width(input int ndig);
    int w;
    if (ndig > 1) begin
      w = $clog2(ndig);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full adders. Besides the sum
// and carry out it exposes the carry into its MSB, needed for signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT-1:0] s_s;
  logic             carry_s;
  logic             carry_next_s;

  // Ripple the carry through DIGIT full adders, least-significant bit first.
  always_comb begin
    s_s          = '0;
    carry_s      = cin;
    carry_next_s = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      s_s[i]       = a[i] ^ b[i] ^ carry_s;
      carry_next_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
      carry_s      = carry_next_s;
    end
  end

  assign s     = s_s;
  assign cout  = carry_s;
  // The carry into the MSB is recovered from the MSB's own sum bit.
  assign c_msb = s_s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor processing DIGIT bits per clock,
// least-significant digit first, with valid/ready handshakes on both sides.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_e           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             c_out_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout_s;
  logic             dig_cmsb_s;
  logic [WIDTH-1:0] sum_next_s;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a     (a_sh_r[DIGIT-1:0]),
    .b     (b_sh_r[DIGIT-1:0]),
    .cin   (carry_r),
    .s     (dig_s),
    .cout  (dig_cout_s),
    .c_msb (dig_cmsb_s)
  );

  // The new digit enters at the top of the sum register; after NDIG shifts
  // the first digit has reached bit 0.
  generate
    if (NDIG == 1) begin : g_single
      assign sum_next_s = dig_s;
    end else begin : g_multi
      assign sum_next_s = {dig_s, sum_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Handshake FSM together with the operand, carry, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r      <= a;
            // Subtraction is a + ~b + !c_in, so B is stored inverted and the
            // carry register starts at the complemented borrow.
            b_sh_r      <= sub ? ~b : b;
            carry_r     <= c_in ^ sub;
            cnt_r       <= '0;
            state_r     <= BUSY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
          end
        end
        BUSY: begin
          a_sh_r  <= a_sh_r >> DIGIT;
          b_sh_r  <= b_sh_r >> DIGIT;
          sum_r   <= sum_next_s;
          carry_r <= dig_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_DIG) begin
            c_out_r     <= dig_cout_s;
            ovf_r       <= dig_cmsb_s ^ dig_cout_s;
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table-driven directed vectors, hand-written backpressure
// and reset sequences, and randomized operations checked against an
// arithmetic reference model.
module tb_serial_addsub;

  localparam int WIDTH = 20;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             c_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             o;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             ci;
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
    int               stall;
    string            name;
  } vec_t;

  vec_t tbl[6];

  serial_addsub #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s, input logic ci);
    longint ux, uy, sx, sy, ur, sr, c;
    res_t   r;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    c  = ci;
    if (s) begin
      ur  = ux - uy - c;
      sr  = sx - sy - c;
      r.c = (ux >= uy + c);
    end else begin
      ur  = ux + uy + c;
      sr  = sx + sy + c;
      r.c = (ur >= 64'(2 ** WIDTH));
    end
    r.sum = ur[WIDTH-1:0];
    r.o   = (sr > 64'(2 ** (WIDTH - 1)) - 1) || (sr < -64'(2 ** (WIDTH - 1)));
    return r;
  endfunction

  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input logic ci, input string tag);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = x; b = y; sub = s; c_in = ci; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    sub = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic s, input logic ci, input int stall,
                        input res_t exp, input string tag);
    int lat = 0;
    start_op(x, y, s, ci, tag);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(NDIG));
    chk({tag, ".sum"}, 32'(sum), 32'(exp.sum));
    chk({tag, ".c_out"}, 32'(c_out), 32'(exp.c));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp.o));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".held_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".held_sum"}, 32'(sum), 32'(exp.sum));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, ".valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    res_t e;
    logic [WIDTH-1:0] ra, rb;
    logic             rs, rc;

    tbl[0] = '{20'h00001, 20'h00002, 1'b0, 1'b0, 20'h00003, 1'b0, 1'b0, 0, "add_small"};
    tbl[1] = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 1, "add_wrap"};
    tbl[2] = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1, 0, "add_ovf"};
    tbl[3] = '{20'h00005, 20'h00007, 1'b1, 1'b0, 20'hFFFFE, 1'b0, 1'b0, 2, "sub_neg"};
    tbl[4] = '{20'h80000, 20'h00001, 1'b1, 1'b0, 20'h7FFFF, 1'b1, 1'b1, 0, "sub_ovf"};
    tbl[5] = '{20'h12345, 20'h11111, 1'b0, 1'b0, 20'h23456, 1'b0, 1'b0, 0, "post_reset"};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.c_out", 32'(c_out), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      e.sum = tbl[i].es; e.c = tbl[i].ec; e.o = tbl[i].eo;
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].ci, tbl[i].stall, e, tbl[i].name);
    end

    // Backpressure with new operands offered during DONE.
    start_op(20'h0ABCD, 20'h01234, 1'b0, 1'b1, "bp");
    for (int i = 0; i < NDIG; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp.valid", 32'(out_valid), 32'd1);
    chk("bp.c_out", 32'(c_out), 32'd0);
    in_valid = 1'b1; a = 20'h55555; b = 20'h22222; sub = 1'b1; c_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.sum", 32'(sum), 32'h0BE02);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.idle_ready", 32'(in_ready), 32'd1);
    chk("bp.idle_valid", 32'(out_valid), 32'd0);
    chk("bp.idle_sum", 32'(sum), 32'h0BE02);
    for (int i = 0; i < NDIG + 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp.not_queued", 32'(out_valid), 32'd0);
    end

    // Reset during the second BUSY cycle.
    start_op(20'hFFFFF, 20'hFFFFF, 1'b0, 1'b1, "rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.sum", 32'(sum), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    e.sum = tbl[5].es; e.c = tbl[5].ec; e.o = tbl[5].eo;
    run_op(tbl[5].a, tbl[5].b, tbl[5].s, tbl[5].ci, tbl[5].stall, e, tbl[5].name);

    // Randomized operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      e  = model(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc, $urandom_range(0, 3), e, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
